event_vector_ring: RTL and testbench

EVENT_VECTOR_RING -- requirements
Module: event_vector_ring

---
 rtl/event_vector_ring.sv | 121 ++++++++++++
 tb/tb_event_vector_ring.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_vector_ring.sv
// Barrel-thread event vector ring: one slot per thread per revolution, issuing
// clear (reset) vectors ahead of interrupt vectors, with per-thread in-service tracking.
module event_vector_ring #(
    parameter int                  THREADS   = 8,
    parameter int                  THRD_W    = 3,
    parameter int                  ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]   CLR_BASE  = 'h0,
    parameter int                  CLR_SPAN  = 2,
    parameter logic [ADDR_W-1:0]   INTR_BASE = 'h20,
    parameter int                  INTR_SPAN = 2,
    parameter logic [THREADS-1:0]  INTR_EDGE = '1,
    parameter bit                  RST_CLR   = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [THREADS-1:0]  clr_req_i,
    input  logic [THREADS-1:0]  intr_req_i,
    input  logic [THREADS-1:0]  intr_en_i,
    input  logic                iret_i,
    input  logic [THRD_W-1:0]   iret_thrd_i,
    output logic [THRD_W-1:0]   thrd_o,
    output logic                vec_vld_o,
    output logic                vec_clr_o,
    output logic [THRD_W-1:0]   vec_thrd_o,
    output logic [ADDR_W-1:0]   vec_addr_o,
    output logic [THREADS-1:0]  clr_ack_o,
    output logic [THREADS-1:0]  intr_ack_o,
    output logic [THREADS-1:0]  isr_o
);

    // Base bits that overlap the thread/spacing field are dropped.
    localparam logic [ADDR_W-1:0] CLR_HI  = CLR_BASE  & ({ADDR_W{1'b1}} << (THRD_W + CLR_SPAN));
    localparam logic [ADDR_W-1:0] INTR_HI = INTR_BASE & ({ADDR_W{1'b1}} << (THRD_W + INTR_SPAN));

    function automatic logic [ADDR_W-1:0] form_addr(input logic [ADDR_W-1:0] hi,
                                                    input int                span,
                                                    input logic [THRD_W-1:0] t);
        return hi | (ADDR_W'(t) << span);
    endfunction

    logic [THRD_W-1:0]  thrd_p0;
    logic [THREADS-1:0] clr_pend_q, edge_pend_q, intr_req_q, isr_q;

    logic [THREADS-1:0] slot_oh, intr_pend, edge_rise;
    logic [THREADS-1:0] clr_pend_n, edge_pend_n, isr_n;
    logic               issue_clr, issue_intr;

    logic               vld_p1, clr_p1;
    logic [THRD_W-1:0]  thrd_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [THREADS-1:0] clr_ack_p1, intr_ack_p1;

    // ---- stage p0: slot decision for thread thrd_p0 ----
    always_comb begin
        slot_oh    = THREADS'(1) << thrd_p0;
        edge_rise  = intr_req_i & ~intr_req_q;
        intr_pend  = (INTR_EDGE & edge_pend_q) | (~INTR_EDGE & intr_req_i);
        issue_clr  = |(clr_pend_q & slot_oh);
        issue_intr = !issue_clr && |(intr_pend & intr_en_i & ~isr_q & slot_oh);

        // A request landing on the issuing edge re-arms the flag.
        clr_pend_n  = (clr_pend_q & ~(slot_oh & {THREADS{issue_clr}})) | clr_req_i;
        edge_pend_n = ((edge_pend_q & ~(slot_oh & {THREADS{issue_clr | issue_intr}}))
                       | edge_rise) & INTR_EDGE;

        // Clear wins over both iret and a fresh interrupt on the same thread.
        isr_n = isr_q;
        if (iret_i)
            isr_n[iret_thrd_i] = 1'b0;
        if (issue_intr)
            isr_n = isr_n | slot_oh;
        if (issue_clr)
            isr_n = isr_n & ~slot_oh;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thrd_p0     <= '0;
            clr_pend_q  <= {THREADS{RST_CLR}};
            edge_pend_q <= '0;
            intr_req_q  <= '0;
            isr_q       <= '0;
        end else begin
            thrd_p0     <= (thrd_p0 == THRD_W'(THREADS - 1)) ? '0 : thrd_p0 + THRD_W'(1);
            clr_pend_q  <= clr_pend_n;
            edge_pend_q <= edge_pend_n;
            intr_req_q  <= intr_req_i;
            isr_q       <= isr_n;
        end
    end

    // ---- stage p1: registered vector outputs ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_p1      <= 1'b0;
            clr_p1      <= 1'b0;
            thrd_p1     <= '0;
            addr_p1     <= '0;
            clr_ack_p1  <= '0;
            intr_ack_p1 <= '0;
        end else begin
            vld_p1      <= issue_clr | issue_intr;
            clr_p1      <= issue_clr;
            thrd_p1     <= (issue_clr | issue_intr) ? thrd_p0 : '0;
            addr_p1     <= issue_clr  ? form_addr(CLR_HI,  CLR_SPAN,  thrd_p0) :
                           issue_intr ? form_addr(INTR_HI, INTR_SPAN, thrd_p0) : '0;
            clr_ack_p1  <= slot_oh & {THREADS{issue_clr}};
            intr_ack_p1 <= slot_oh & {THREADS{issue_intr}};
        end
    end

    assign thrd_o     = thrd_p0;
    assign vec_vld_o  = vld_p1;
    assign vec_clr_o  = clr_p1;
    assign vec_thrd_o = thrd_p1;
    assign vec_addr_o = addr_p1;
    assign clr_ack_o  = clr_ack_p1;
    assign intr_ack_o = intr_ack_p1;
    assign isr_o      = isr_q;

endmodule

// File: tb/tb_event_vector_ring.sv
// Directed bench for event_vector_ring: reset clears, edge/level interrupts,
// clear-over-interrupt priority, iret/slot collision and mid-operation reset.
module tb_event_vector_ring;

    localparam int N  = 8;
    localparam int TW = 3;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  clr_req, intr_req, intr_en;
    logic          iret;
    logic [TW-1:0] iret_thrd;
    logic [TW-1:0] thrd;
    logic          vec_vld, vec_clr;
    logic [TW-1:0] vec_thrd;
    logic [AW-1:0] vec_addr;
    logic [N-1:0]  clr_ack, intr_ack, isr;

    int n_tests = 0;
    int n_fail  = 0;

    // Captured by window(): vector count and the last vector seen.
    int            nvec;
    logic [AW-1:0] w_addr;
    logic          w_clr;
    logic [TW-1:0] w_thrd;
    logic [N-1:0]  w_clr_ack, w_intr_ack;

    event_vector_ring #(
        .THREADS(N), .THRD_W(TW), .ADDR_W(AW),
        .CLR_BASE(16'h0), .CLR_SPAN(2),
        .INTR_BASE(16'h20), .INTR_SPAN(2),
        .INTR_EDGE(8'hDF), .RST_CLR(1'b1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .clr_req_i(clr_req), .intr_req_i(intr_req), .intr_en_i(intr_en),
        .iret_i(iret), .iret_thrd_i(iret_thrd),
        .thrd_o(thrd), .vec_vld_o(vec_vld), .vec_clr_o(vec_clr),
        .vec_thrd_o(vec_thrd), .vec_addr_o(vec_addr),
        .clr_ack_o(clr_ack), .intr_ack_o(intr_ack), .isr_o(isr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic window(input int cycles);
        logic [TW-1:0] prev;
        nvec = 0; w_addr = '0; w_clr = 1'b0; w_thrd = '0; w_clr_ack = '0; w_intr_ack = '0;
        for (int i = 0; i < cycles; i++) begin
            prev = thrd;
            tick();
            chk("ring_step", thrd, (prev == TW'(N - 1)) ? 0 : prev + 1);
            if (vec_vld) begin
                nvec++;
                w_addr = vec_addr; w_clr = vec_clr; w_thrd = vec_thrd;
                w_clr_ack = clr_ack; w_intr_ack = intr_ack;
            end else begin
                chk("idle_zero", {vec_addr, vec_clr, vec_thrd, clr_ack, intr_ack}, 0);
            end
        end
    endtask

    task automatic pulse_intr(input int t);
        intr_req[t] = 1'b1;
        tick();
        intr_req[t] = 1'b0;
    endtask

    task automatic pulse_clr(input int t);
        clr_req[t] = 1'b1;
        tick();
        clr_req[t] = 1'b0;
    endtask

    task automatic do_iret(input int t);
        iret = 1'b1;
        iret_thrd = TW'(t);
        tick();
        iret = 1'b0;
    endtask

    task automatic wait_slot(input int t);
        for (int i = 0; i < 2 * N && thrd != TW'(t); i++)
            tick();
        chk("wait_slot", thrd, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int quiet;
        rst_n = 1'b0; clr_req = '0; intr_req = '0; intr_en = '1;
        iret = 1'b0; iret_thrd = '0;
        repeat (3) @(negedge clk);
        chk("rst_thrd", thrd, 0);
        chk("rst_vec", {vec_vld, vec_clr, vec_thrd, vec_addr}, 0);
        chk("rst_acks", {clr_ack, intr_ack}, 0);
        chk("rst_isr", isr, 0);

        // Reset-time clear vectors for every thread in ring order.
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            tick();
            chk("boot_vld", vec_vld, 1);
            chk("boot_clr", vec_clr, 1);
            chk("boot_thrd", vec_thrd, i);
            chk("boot_addr", vec_addr, i * 4);
            chk("boot_ack", clr_ack, 1 << i);
            chk("boot_iack", intr_ack, 0);
        end
        chk("ring_wrap", thrd, 0);
        window(N);
        chk("boot_quiet", nvec, 0);

        // Edge interrupt on thread 3; second edge waits for iret.
        pulse_intr(3);
        window(2 * N);
        chk("e3_count", nvec, 1);
        chk("e3_addr", w_addr, 16'h2C);
        chk("e3_clr", w_clr, 0);
        chk("e3_thrd", w_thrd, 3);
        chk("e3_iack", w_intr_ack, 8'h08);
        chk("e3_isr", isr, 8'h08);
        pulse_intr(3);
        window(2 * N);
        chk("e3_held", nvec, 0);
        do_iret(3);
        window(2 * N);
        chk("e3_after_iret", nvec, 1);
        chk("e3_addr2", w_addr, 16'h2C);
        chk("e3_isr2", isr, 8'h08);
        do_iret(3);
        chk("e3_isr_clr", isr, 0);

        // Level interrupt on thread 5: one vector per iret, none when disabled.
        intr_req[5] = 1'b1;
        window(2 * N);
        chk("l5_count", nvec, 1);
        chk("l5_addr", w_addr, 16'h34);
        for (int k = 0; k < 2; k++) begin
            do_iret(5);
            window(2 * N);
            chk("l5_per_iret", nvec, 1);
            chk("l5_addr_k", w_addr, 16'h34);
        end
        intr_en[5] = 1'b0;
        do_iret(5);
        window(2 * N);
        chk("l5_disabled", nvec, 0);
        chk("l5_isr", isr[5], 0);
        intr_req[5] = 1'b0;
        intr_en = '1;

        // Clear and edge interrupt both pending on thread 2: clear wins.
        pulse_intr(2);
        window(2 * N);
        chk("c2_intr", w_addr, 16'h28);
        chk("c2_isr_set", isr[2], 1);
        pulse_intr(2);
        pulse_clr(2);
        window(2 * N);
        chk("c2_count", nvec, 1);
        chk("c2_is_clr", w_clr, 1);
        chk("c2_addr", w_addr, 16'h08);
        chk("c2_ack", w_clr_ack, 8'h04);
        chk("c2_no_iack", w_intr_ack, 0);
        chk("c2_isr", isr[2], 0);
        window(2 * N);
        chk("c2_discard", nvec, 0);

        // iret on thread 6 coinciding with its slot blocks this visit only.
        pulse_intr(6);
        window(2 * N);
        chk("i6_first", w_addr, 16'h38);
        pulse_intr(6);
        wait_slot(6);
        iret = 1'b1; iret_thrd = 3'd6;
        tick();
        iret = 1'b0;
        chk("i6_blocked", vec_vld, 0);
        quiet = 0;
        for (int i = 1; i < N; i++) begin
            tick();
            if (vec_vld) quiet++;
        end
        chk("i6_gap", quiet, 0);
        tick();
        chk("i6_vld", vec_vld, 1);
        chk("i6_addr", vec_addr, 16'h38);
        chk("i6_thrd", vec_thrd, 6);
        chk("i6_iack", intr_ack, 8'h40);
        chk("i6_isr", isr, 8'h40);

        // Reset asserted just before a pending clear issues.
        pulse_clr(1);
        wait_slot(1);
        rst_n = 1'b0;
        #1;
        chk("ar_thrd", thrd, 0);
        chk("ar_isr", isr, 0);
        chk("ar_vec", {vec_vld, vec_addr, vec_clr, vec_thrd}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ar_no_vld", vec_vld, 0);
        chk("ar_no_ack", {clr_ack, intr_ack}, 0);
        rst_n = 1'b1;
        tick();
        chk("ar_reboot_vld", {vec_vld, vec_clr}, 2'b11);
        chk("ar_reboot_thrd", vec_thrd, 0);
        chk("ar_reboot_ack", clr_ack, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
